// File: rtl/instruction_pkg.sv
// Shared instruction-stream types: the fetch queue entry and instruction size.
package instruction_pkg;

    localparam logic [31:0] INST_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; flush wins over push and pop.
// Head is read straight from storage, so a push is visible the cycle after.
module fetch_queue
    import instruction_pkg::*;
#(
    parameter  int unsigned QDEPTH = 2,
    localparam int unsigned CNT_W  = $clog2(QDEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       push_entry,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output fetch_entry_t       head
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);

    fetch_entry_t             mem_q [QDEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     wr_en;

    assign wr_en = push && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: reset is sampled on the clock edge only; sequential state uses <=.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_entry;
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    assert property (@(posedge clk) disable iff (reset)
        (push && !flush) |-> (count_q != CNT_W'(QDEPTH)));

endmodule

// File: rtl/fetch.sv
// Instruction fetch front end: credit-limited sequential reads, flushable queue.
// Optional FETCH_PERF_EN adds delivered-instruction and redirect counters.
module fetch
    import instruction_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_v_x,
    input  logic [31:0] pc_x,
    output logic [31:0] pc_o,
    output logic        inst_v_o,
    output logic [31:0] inst_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_inst_o,
    output logic [31:0] perf_flush_o
`endif
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [CNT_W-1:0] q_count;
    logic             q_empty;
    fetch_entry_t     q_head;

    logic             pop, grant, rvalid, keep;
    logic [SUM_W-1:0] credit_used;
    logic [31:0]      target;

    assign target   = align_pc(pc_x);
    assign inst_v_o = !q_empty && !pc_v_x;
    assign pop      = inst_v_o;

    // Outstanding requests already own queue slots, so the queue cannot overflow.
    assign credit_used = {1'b0, q_count} + {1'b0, outstanding_q} - SUM_W'(pop);
    assign imem_req_o  = !reset && !pc_v_x && (credit_used < SUM_W'(QDEPTH));
    assign imem_addr_o = fetch_pc_q;

    assign grant  = imem_req_o && imem_gnt_i;
    assign rvalid = imem_rvalid_i && !reset;
    assign keep   = rvalid && !pc_v_x && (drop_q == '0);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(rvalid);
        if (pc_v_x) begin
            fetch_pc_d = target;
            resp_pc_d  = target;
            // The response landing now is discarded by the flush, not by drop.
            drop_d     = outstanding_q - CNT_W'(rvalid);
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + INST_BYTES;
            if (rvalid) begin
                if (drop_q != '0) drop_d = drop_q - CNT_W'(1);
                else              resp_pc_d = resp_pc_q + INST_BYTES;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (keep),
        .pop        (pop),
        .flush      (pc_v_x),
        .push_entry ('{pc: resp_pc_q, inst: imem_rdata_i}),
        .count      (q_count),
        .empty      (q_empty),
        .head       (q_head)
    );

    assign pc_o   = q_head.pc;
    assign inst_o = q_head.inst;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_inst_q, perf_inst_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_inst_d  = perf_inst_q + 32'(inst_v_o);
        perf_flush_d = perf_flush_q + 32'(pc_v_x);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_inst_q  <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_inst_q  <= perf_inst_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_inst_o  = perf_inst_q;
    assign perf_flush_o = perf_flush_q;
`endif

endmodule
